// File: rtl/z80_alu_pkg.sv
// Shared types and helpers for the ALU writeback stage: opcode encoding, flag bit
// positions, writeback FSM states and the parity function used for P/V.
package z80_alu_pkg;

    typedef enum logic [4:0] {
        OpAdd     = 5'd0,
        OpSub     = 5'd1,
        OpAnd     = 5'd2,
        OpOr      = 5'd3,
        OpXor     = 5'd4,
        OpCompare = 5'd5,
        OpSll     = 5'd6,
        OpSrl     = 5'd7,
        OpSla     = 5'd8,
        OpSra     = 5'd9,
        OpRol     = 5'd10,
        OpRor     = 5'd11,
        OpInc     = 5'd12,
        OpDec     = 5'd13
    } alu_op_e;

    localparam logic [4:0] OP_LAST = 5'd13;

    localparam int unsigned FLAG_S = 7;
    localparam int unsigned FLAG_Z = 6;
    localparam int unsigned FLAG_Y = 5;
    localparam int unsigned FLAG_H = 4;
    localparam int unsigned FLAG_X = 3;
    localparam int unsigned FLAG_P = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_C = 0;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StHold = 1'b1
    } wb_state_e;

    // Z80 P flag: 1 when the number of set bits is even.
    function automatic logic parity8(input logic [7:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational Z80 flag generation from ALU operands, opcode and result; COMPARE
// recomputes a-b here because the ALU itself returns zero for that opcode.
module alu_flag_calc
    import z80_alu_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic [4:0] opcode_i,
    input  logic [7:0] result_i,
    input  logic [7:0] flags_i,
    output logic [7:0] flags_o,
    output logic       result_valid_o
);

    logic [8:0] sum;
    logic [7:0] diff;
    logic [7:0] res_eff;
    logic [7:0] yx_src;
    logic       half_add;
    logic       half_sub;
    logic       v_add;
    logic       v_sub;
    logic [3:0] sll_tmp;
    logic [3:0] srl_tmp;
    logic [2:0] sll_idx;
    logic [2:0] srl_idx;
    logic       b_zero;
    logic       b_le7;
    logic       b_le8;

    always_comb begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        diff     = a_i - b_i;
        half_add = ({1'b0, a_i[3:0]} + {1'b0, b_i[3:0]}) > 5'd15;
        half_sub = a_i[3:0] < b_i[3:0];
        v_add    = (a_i[7] == b_i[7]) && (sum[7] != a_i[7]);
        v_sub    = (a_i[7] != b_i[7]) && (diff[7] != a_i[7]);
        // Bit indices for shift carry-out; only meaningful when 1 <= b <= 8.
        sll_tmp  = 4'd8 - b_i[3:0];
        srl_tmp  = b_i[3:0] - 4'd1;
        sll_idx  = sll_tmp[2:0];
        srl_idx  = srl_tmp[2:0];
        b_zero   = (b_i == 8'd0);
        b_le7    = (b_i <= 8'd7);
        b_le8    = (b_i <= 8'd8);
    end

    always_comb begin
        result_valid_o = (opcode_i <= OP_LAST);
        res_eff        = (opcode_i == OpCompare) ? diff : result_i;
        yx_src         = (opcode_i == OpCompare) ? b_i : result_i;

        flags_o         = 8'h00;
        flags_o[FLAG_S] = res_eff[7];
        flags_o[FLAG_Z] = (res_eff == 8'h00);
        flags_o[FLAG_Y] = yx_src[5];
        flags_o[FLAG_X] = yx_src[3];

        case (opcode_i)
            OpAdd: begin
                flags_o[FLAG_H] = half_add;
                flags_o[FLAG_P] = v_add;
                flags_o[FLAG_C] = sum[8];
            end
            OpSub, OpCompare: begin
                flags_o[FLAG_H] = half_sub;
                flags_o[FLAG_P] = v_sub;
                flags_o[FLAG_N] = 1'b1;
                flags_o[FLAG_C] = a_i < b_i;
            end
            OpAnd: begin
                flags_o[FLAG_H] = 1'b1;
                flags_o[FLAG_P] = parity8(res_eff);
            end
            OpOr, OpXor: begin
                flags_o[FLAG_P] = parity8(res_eff);
            end
            OpSll, OpSla: begin
                flags_o[FLAG_P] = parity8(res_eff);
                if (b_zero)     flags_o[FLAG_C] = flags_i[FLAG_C];
                else if (b_le8) flags_o[FLAG_C] = a_i[sll_idx];
                else            flags_o[FLAG_C] = 1'b0;
            end
            OpSrl: begin
                flags_o[FLAG_P] = parity8(res_eff);
                if (b_zero)     flags_o[FLAG_C] = flags_i[FLAG_C];
                else if (b_le8) flags_o[FLAG_C] = a_i[srl_idx];
                else            flags_o[FLAG_C] = 1'b0;
            end
            OpSra: begin
                flags_o[FLAG_P] = parity8(res_eff);
                if (b_zero)     flags_o[FLAG_C] = flags_i[FLAG_C];
                else if (b_le7) flags_o[FLAG_C] = a_i[srl_idx];
                else            flags_o[FLAG_C] = a_i[7];
            end
            OpRol: begin
                flags_o[FLAG_P] = parity8(res_eff);
                flags_o[FLAG_C] = (b_i[2:0] == 3'd0) ? flags_i[FLAG_C] : res_eff[0];
            end
            OpRor: begin
                flags_o[FLAG_P] = parity8(res_eff);
                flags_o[FLAG_C] = (b_i[2:0] == 3'd0) ? flags_i[FLAG_C] : res_eff[7];
            end
            OpInc: begin
                flags_o[FLAG_H] = (a_i[3:0] == 4'hF);
                flags_o[FLAG_P] = (a_i == 8'h7F);
                flags_o[FLAG_C] = flags_i[FLAG_C];
            end
            OpDec: begin
                flags_o[FLAG_H] = (a_i[3:0] == 4'h0);
                flags_o[FLAG_P] = (a_i == 8'h80);
                flags_o[FLAG_N] = 1'b1;
                flags_o[FLAG_C] = flags_i[FLAG_C];
            end
            default: flags_o = flags_i;
        endcase
    end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: commits results to A/F or holds them for the register file
// on a valid/ready port; supports direct A/F loads and flags illegal opcodes.
module alu_writeback
    import z80_alu_pkg::*;
#(
    parameter logic [7:0] RESET_ACC   = 8'h00,
    parameter logic [7:0] RESET_FLAGS = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    input  logic [4:0] in_opcode,
    input  logic [7:0] in_result,
    input  logic       in_to_acc,
    input  logic [2:0] in_reg_sel,
    input  logic       load_valid,
    input  logic [7:0] load_acc,
    input  logic [7:0] load_flags,
    output logic [7:0] acc_q,
    output logic [7:0] flags_q,
    output logic       wb_valid,
    input  logic       wb_ready,
    output logic [2:0] wb_sel,
    output logic [7:0] wb_data,
    output logic       illegal_op
);

    wb_state_e  state_q, state_d;
    logic [7:0] acc_d, flags_d;
    logic [7:0] wb_data_q, wb_data_d;
    logic [2:0] wb_sel_q, wb_sel_d;
    logic       illegal_q, illegal_d;

    logic [7:0] flags_new;
    logic       op_legal;
    logic       accept;
    logic       wb_done;

    alu_flag_calc u_flag_calc (
        .a_i            (in_a),
        .b_i            (in_b),
        .opcode_i       (in_opcode),
        .result_i       (in_result),
        .flags_i        (flags_q),
        .flags_o        (flags_new),
        .result_valid_o (op_legal)
    );

    // Outputs of the FSM and the input handshake.
    always_comb begin
        wb_valid = (state_q == StHold);
        in_ready = rst_n & ~load_valid & ((state_q == StIdle) | wb_ready);
    end

    assign accept  = in_valid & in_ready;
    assign wb_done = (state_q == StHold) & wb_ready;

    always_comb begin
        state_d = state_q;
        if (wb_done) begin
            state_d = StIdle;
        end
        if (accept && op_legal && !in_to_acc) begin
            state_d = StHold;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        acc_d     = acc_q;
        flags_d   = flags_q;
        wb_data_d = wb_data_q;
        wb_sel_d  = wb_sel_q;
        illegal_d = accept & ~op_legal;
        // in_ready is low during a load, so a load never races an accepted op.
        if (load_valid) begin
            acc_d   = load_acc;
            flags_d = load_flags;
        end else if (accept && op_legal) begin
            flags_d = flags_new;
            if (in_to_acc) begin
                if (in_opcode != OpCompare) begin
                    acc_d = in_result;
                end
            end else begin
                wb_data_d = in_result;
                wb_sel_d  = in_reg_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q     <= RESET_ACC;
            flags_q   <= RESET_FLAGS;
            wb_data_q <= 8'h00;
            wb_sel_q  <= 3'd0;
            illegal_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            flags_q   <= flags_d;
            wb_data_q <= wb_data_d;
            wb_sel_q  <= wb_sel_d;
            illegal_q <= illegal_d;
        end
    end

    assign wb_data    = wb_data_q;
    assign wb_sel     = wb_sel_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback with hand-computed A/F and
// writeback expectations.
module tb_alu_writeback;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4;
    localparam logic [4:0] OP_CMP = 5'd5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a, in_b, in_result;
    logic [4:0] in_opcode;
    logic       in_to_acc;
    logic [2:0] in_reg_sel;
    logic       load_valid;
    logic [7:0] load_acc, load_flags;
    logic [7:0] acc_q, flags_q;
    logic       wb_valid;
    logic       wb_ready;
    logic [2:0] wb_sel;
    logic [7:0] wb_data;
    logic       illegal_op;

    integer n_checks = 0;
    integer n_fail   = 0;

    always #5 clk = ~clk;

    alu_writeback dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_opcode  (in_opcode),
        .in_result  (in_result),
        .in_to_acc  (in_to_acc),
        .in_reg_sel (in_reg_sel),
        .load_valid (load_valid),
        .load_acc   (load_acc),
        .load_flags (load_flags),
        .acc_q      (acc_q),
        .flags_q    (flags_q),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_sel     (wb_sel),
        .wb_data    (wb_data),
        .illegal_op (illegal_op)
    );

    task automatic set_op(input logic [7:0] a, input logic [7:0] b, input logic [4:0] op,
                          input logic [7:0] res, input logic to_acc, input logic [2:0] sel);
        in_valid   = 1'b1;
        in_a       = a;
        in_b       = b;
        in_opcode  = op;
        in_result  = res;
        in_to_acc  = to_acc;
        in_reg_sel = sel;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        set_op(8'h11, 8'h22, OP_ADD, 8'h33, 1'b1, 3'd0);
        wb_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (acc_q !== 8'h00) begin n_fail++;
            $display("FAIL reset_acc got %h want 00", acc_q); end
        n_checks++; if (flags_q !== 8'h00) begin n_fail++;
            $display("FAIL reset_flags got %h want 00", flags_q); end
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
        n_checks++; if ({wb_sel, wb_data} !== 11'd0) begin n_fail++;
            $display("FAIL reset_wb_regs got %h/%h want 0/00", wb_sel, wb_data); end
        n_checks++; if (illegal_op !== 1'b0) begin n_fail++;
            $display("FAIL reset_illegal got %b want 0", illegal_op); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++;
            $display("FAIL reset_in_ready got %b want 0", in_ready); end
        in_valid = 1'b0;
        wb_ready = 1'b0;
        rst_n    = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL idle_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_add;
        @(negedge clk);
        set_op(8'h7F, 8'h01, OP_ADD, 8'h80, 1'b1, 3'd0);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (acc_q !== 8'h80) begin n_fail++;
            $display("FAIL add_acc got %h want 80", acc_q); end
        n_checks++; if (flags_q !== 8'h94) begin n_fail++;
            $display("FAIL add_flags got %h want 94", flags_q); end
    endtask

    task automatic test_compare;
        @(negedge clk);
        set_op(8'h10, 8'h20, OP_CMP, 8'h00, 1'b1, 3'd0);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (acc_q !== 8'h80) begin n_fail++;
            $display("FAIL cmp_acc got %h want 80", acc_q); end
        n_checks++; if (flags_q !== 8'hA3) begin n_fail++;
            $display("FAIL cmp_flags got %h want a3", flags_q); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        wb_ready = 1'b0;
        set_op(8'h05, 8'h03, OP_SUB, 8'h02, 1'b0, 3'd5);
        @(negedge clk);
        set_op(8'h01, 8'h01, OP_ADD, 8'h02, 1'b1, 3'd0);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (wb_valid !== 1'b1) begin n_fail++;
                $display("FAIL hold_wb_valid[%0d] got %b want 1", i, wb_valid); end
            n_checks++; if (wb_data !== 8'h02 || wb_sel !== 3'd5) begin n_fail++;
                $display("FAIL hold_wb_payload[%0d] got %h/%h want 5/02", i, wb_sel, wb_data);
            end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++;
                $display("FAIL hold_in_ready[%0d] got %b want 0", i, in_ready); end
            n_checks++; if (acc_q !== 8'h80 || flags_q !== 8'h02) begin n_fail++;
                $display("FAIL hold_af[%0d] got %h/%h want 80/02", i, acc_q, flags_q); end
            @(negedge clk);
            #1;
        end
        wb_ready = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL release_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        wb_ready = 1'b0;
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++;
            $display("FAIL release_wb_valid got %b want 0", wb_valid); end
        n_checks++; if (acc_q !== 8'h02 || flags_q !== 8'h00) begin n_fail++;
            $display("FAIL release_af got %h/%h want 02/00", acc_q, flags_q); end
    endtask

    task automatic test_load_priority;
        @(negedge clk);
        load_valid = 1'b1;
        load_acc   = 8'h3C;
        load_flags = 8'h41;
        set_op(8'h0F, 8'hF0, OP_XOR, 8'hFF, 1'b1, 3'd0);
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++;
            $display("FAIL load_in_ready got %b want 0", in_ready); end
        @(negedge clk);
        load_valid = 1'b0;
        n_checks++; if (acc_q !== 8'h3C || flags_q !== 8'h41) begin n_fail++;
            $display("FAIL load_af got %h/%h want 3c/41", acc_q, flags_q); end
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL post_load_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (acc_q !== 8'hFF || flags_q !== 8'hAC) begin n_fail++;
            $display("FAIL xor_af got %h/%h want ff/ac", acc_q, flags_q); end
    endtask

    task automatic test_shifts;
        // SRA b=9, ROL b=0 keeps C, SLL b=1, SRL b=9, INC 7F, DEC 80
        logic [7:0] va [6] = '{8'h80, 8'h55, 8'h81, 8'h01, 8'h7F, 8'h80};
        logic [7:0] vb [6] = '{8'h09, 8'h00, 8'h01, 8'h09, 8'h00, 8'h00};
        logic [4:0] vop[6] = '{5'd9, 5'd10, 5'd6, 5'd7, 5'd12, 5'd13};
        logic [7:0] vr [6] = '{8'hFF, 8'h55, 8'h02, 8'h00, 8'h80, 8'h7F};
        logic [7:0] vf [6] = '{8'hAD, 8'h05, 8'h01, 8'h44, 8'h94, 8'h3E};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_op(va[i], vb[i], vop[i], vr[i], 1'b1, 3'd0);
            @(negedge clk);
            in_valid = 1'b0;
            n_checks++; if (acc_q !== vr[i]) begin n_fail++;
                $display("FAIL shift_acc[%0d] got %h want %h", i, acc_q, vr[i]); end
            n_checks++; if (flags_q !== vf[i]) begin n_fail++;
                $display("FAIL shift_flags[%0d] got %h want %h", i, flags_q, vf[i]); end
        end
    endtask

    task automatic test_illegal;
        @(negedge clk);
        set_op(8'h12, 8'h34, 5'h1F, 8'hAA, 1'b1, 3'd0);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL illegal_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (illegal_op !== 1'b1) begin n_fail++;
            $display("FAIL illegal_pulse got %b want 1", illegal_op); end
        n_checks++; if (acc_q !== 8'h7F || flags_q !== 8'h3E) begin n_fail++;
            $display("FAIL illegal_af got %h/%h want 7f/3e", acc_q, flags_q); end
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++;
            $display("FAIL illegal_wb got %b want 0", wb_valid); end
        @(negedge clk);
        n_checks++; if (illegal_op !== 1'b0) begin n_fail++;
            $display("FAIL illegal_one_cycle got %b want 0", illegal_op); end
    endtask

    task automatic test_reset_in_hold;
        @(negedge clk);
        wb_ready = 1'b0;
        set_op(8'hF0, 8'h0F, OP_OR, 8'hFF, 1'b0, 3'd2);
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (wb_valid !== 1'b1 || wb_data !== 8'hFF || wb_sel !== 3'd2) begin
            n_fail++;
            $display("FAIL or_hold got %b/%h/%h want 1/2/ff", wb_valid, wb_sel, wb_data);
        end
        n_checks++; if (flags_q !== 8'hAC || acc_q !== 8'h7F) begin n_fail++;
            $display("FAIL or_af got %h/%h want 7f/ac", acc_q, flags_q); end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (wb_valid !== 1'b0) begin n_fail++;
            $display("FAIL rst_hold_wb_valid got %b want 0", wb_valid); end
        n_checks++; if (acc_q !== 8'h00 || flags_q !== 8'h00) begin n_fail++;
            $display("FAIL rst_hold_af got %h/%h want 00/00", acc_q, flags_q); end
        n_checks++; if (wb_data !== 8'h00 || wb_sel !== 3'd0) begin n_fail++;
            $display("FAIL rst_hold_wb_regs got %h/%h want 0/00", wb_sel, wb_data); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++;
            $display("FAIL rst_hold_idle got %b/%b want 0/1", wb_valid, in_ready); end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_a       = 8'h00;
        in_b       = 8'h00;
        in_opcode  = 5'd0;
        in_result  = 8'h00;
        in_to_acc  = 1'b0;
        in_reg_sel = 3'd0;
        load_valid = 1'b0;
        load_acc   = 8'h00;
        load_flags = 8'h00;
        wb_ready   = 1'b0;

        test_reset();
        test_add();
        test_compare();
        test_back_to_back();
        test_load_priority();
        test_shifts();
        test_illegal();
        test_reset_in_hold();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
